gumnut_ctrl_unit: RTL and testbench
===================================

Name: gumnut_ctrl_unit

Overview:
- Control/sequencing stage that sits directly upstream of the datapath unit and drives all of its control inputs: RegWrt_c, ClkEn_e, RegMux_c, op2_c and ALUOp_c.
- Fetches 18-bit instructions over the instruction bus and consumes the datapath's decoded fields (op/func/addr/disp/offset), rs value and flags.
- Owns the 12-bit PC, a return-address stack, and the data/port bus handshakes.

Parameters:
- STACK_DEPTH, 8, number of return-address entries (power of 2, 2..16)
- RESET_PC, 12'h000, PC value after reset

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- inst_ack_i  in  1  instruction bus ack; also wired to the datapath IR enable
- inst_cyc_o  out  1  instruction bus cycle
- inst_stb_o  out  1  instruction bus strobe
- inst_adr_o  out  12  fetch address (= PC)
- op_e  in  3  opcode class from datapath
- func_e  in  3  function code from datapath
- addr_e  in  12  jump target
- disp_e  in  8  signed branch displacement
- offset_e  in  8  memory/port offset
- rs_i  in  8  rs register value (datapath rs_o)
- carry_e  in  1  ALU carry
- zero_e  in  1  ALU zero
- data_ack_i  in  1  data memory ack
- data_cyc_o  out  1  data memory cycle
- data_stb_o  out  1  data memory strobe
- data_we_o  out  1  data memory write enable
- data_adr_o  out  8  data memory address
- port_ack_i  in  1  I/O port ack
- port_cyc_o  out  1  I/O port cycle
- port_stb_o  out  1  I/O port strobe
- port_we_o  out  1  I/O port write enable
- port_adr_o  out  8  I/O port address
- RegWrt_c  out  1  register file write enable
- ClkEn_e  out  1  register file / carry-FF clock enable
- RegMux_c  out  2  write-back source: 00 ALU, 01 data, 10 port
- op2_c  out  1  1 = rs2 operand, 0 = immediate
- ALUOp_c  out  4  ALU operation select
- halt_o  out  1  core halted (stby)

Behaviour:
- Opcode classes (op_e):
  - 000 ALU-reg, 001 ALU-imm, 010 shift
  - 011 mem; func[1:0]: 00 ldm, 01 stm, 10 inp, 11 out
  - 100 branch; func[1:0]: 00 bz, 01 bnz, 10 bc, 11 bnc
  - 101 jump; func[0]: 0 jmp, 1 jsb
  - 110 misc; func: 000 ret, 001 stby, others nop
  - 111 nop
- Reset (rst_i low, async):
  - state=FETCH, PC=RESET_PC, stack pointer=0, flag regs z=c=0.
  - All bus and control outputs 0; RegMux_c=00; halt_o=0.
- FETCH:
  - inst_cyc_o=inst_stb_o=1, inst_adr_o=PC.
  - Hold until inst_ack_i=1, then go to DECODE. Strobes deassert in the cycle after ack.
- DECODE: one cycle; the datapath fields are valid.
  - ALU/shift: go to EXEC.
  - mem: go to MEM.
  - branch: if taken, PC=PC+1+sext(disp_e) (mod 4096); else PC+1. Go to FETCH.
  - jmp: PC=addr_e. jsb: push PC+1, then PC=addr_e.
  - ret: pop into PC.
  - stby: PC+1, go to HALT.
  - nop: PC+1, go to FETCH.
- EXEC: one cycle, then go to FETCH.
  - ClkEn_e=1, RegWrt_c=1, RegMux_c=00, PC+=1.
  - op2_c=1 only for op 000.
  - ALUOp_c={op_e==010, func_e}.
  - Capture z=zero_e, c=carry_e.
- MEM:
  - ldm/stm drive data_*; inp/out drive port_*. Address = rs_i+offset_e (8-bit wrap).
  - we=1 for stm/out.
  - Hold until the matching ack. In the ack cycle, for ldm/inp: ClkEn_e=1, RegWrt_c=1, RegMux_c=01/10.
  - Then PC+=1, go to FETCH. Acks on the non-selected bus are ignored.
- Branch conditions use the registered z/c, never the live flags.
- HALT: halt_o=1, no bus activity. Exit only via reset (or interrupt, see below).
- Stack:
  - Circular, STACK_DEPTH entries.
  - Push at full overwrites the oldest entry and the pointer wraps.
  - Pop at empty returns the stale entry and the pointer wraps.
  - No error flag.
- PC increment wraps 12'hFFF -> 12'h000.
- Reset asserted mid-bus-cycle: strobes drop asynchronously; a late ack after release is ignored (the state is FETCH and waits for a new ack).

Optional Feature:
- Macro: GUMNUT_INT_EN.
- When defined:
  - Adds ports int_req_i (in 1) and int_ack_o (out 1).
  - Adds an interrupt-enable flag (reset 0); misc func 010 = enai, 011 = disi, 100 = reti.
  - When entering FETCH with int_req_i=1 and enable=1: save PC, z and c into shadow registers; clear enable; PC=12'h001; pulse int_ack_o for 1 cycle.
  - reti restores PC, z and c and sets enable.
  - HALT also exits on an enabled interrupt.
- When undefined: no extra ports; misc func 010–100 decode as nop.

Test Plan:
- Reset then ack every fetch on the next cycle: inst_adr_o sequence 000,001,002; add reg instruction -> EXEC cycle with RegWrt_c=1, ClkEn_e=1, op2_c=1, ALUOp_c=0000.
- ALU sets zero_e=1, then bz disp=8'hFE at PC=010 -> next fetch 00F; bnz -> next fetch 011.
- ldm, rs_i=8'h10, offset_e=8'hF8, data_ack_i delayed 3 cycles -> data_adr_o=08, strobes held 3 cycles, write-back RegMux_c=01 in the ack cycle only.
- jsb addr=123 at PC=050, then ret -> fetch 123 then 051; nine nested jsb with STACK_DEPTH=8 -> the ninth ret returns the ninth pushed address (wrap).
- stby -> halt_o=1 and no strobes for 20 cycles; rst_i pulsed low mid-port-cycle -> port_stb_o=0 immediately, fetch restarts at RESET_PC.
- GUMNUT_INT_EN, enai, int_req_i=1 -> int_ack_o pulse, fetch 001; reti -> resume at saved PC with the prior flags.

Source files
------------

// File: rtl/gumnut_ctrl_unit.sv
// Gumnut control stage: fetch/decode sequencing, PC, return stack, bus handshakes.
// Define GUMNUT_INT_EN to add the interrupt request/acknowledge path.
module gumnut_ctrl_unit #(
  parameter int unsigned STACK_DEPTH = 8,
  parameter logic [11:0] RESET_PC    = 12'h000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inst_ack_i,
  output logic        inst_cyc_o,
  output logic        inst_stb_o,
  output logic [11:0] inst_adr_o,
  input  logic [2:0]  op_e,
  input  logic [2:0]  func_e,
  input  logic [11:0] addr_e,
  input  logic [7:0]  disp_e,
  input  logic [7:0]  offset_e,
  input  logic [7:0]  rs_i,
  input  logic        carry_e,
  input  logic        zero_e,
  input  logic        data_ack_i,
  output logic        data_cyc_o,
  output logic        data_stb_o,
  output logic        data_we_o,
  output logic [7:0]  data_adr_o,
  input  logic        port_ack_i,
  output logic        port_cyc_o,
  output logic        port_stb_o,
  output logic        port_we_o,
  output logic [7:0]  port_adr_o,
  output logic        RegWrt_c,
  output logic        ClkEn_e,
  output logic [1:0]  RegMux_c,
  output logic        op2_c,
  output logic [3:0]  ALUOp_c,
  output logic        halt_o
`ifdef GUMNUT_INT_EN
  ,
  input  logic        int_req_i,
  output logic        int_ack_o
`endif
);

  localparam int SW = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [11:0]   pc_q, pc_d, pc_n;
  logic [11:0]   pc_inc, br_tgt;
  logic [SW-1:0] sp_q, sp_d, sp_m1;
  logic [11:0]   stack_q [STACK_DEPTH];
  logic          push;
  logic          z_q, z_d, c_q, c_d;
  logic          taken;
  logic          mem_port, mem_ack;
  logic [7:0]    mem_adr;
  logic          is_alu, is_mem;
  logic          is_br, is_jmp, is_misc;
  logic          int_take;

`ifdef GUMNUT_INT_EN
  logic          ie_q, ie_d;
  logic [11:0]   spc_q;
  logic          sz_q, sc_q;
  logic          int_ack_q;
`endif

  assign pc_inc   = pc_q + 12'd1;
  assign br_tgt   = pc_inc + {{4{disp_e[7]}}, disp_e};
  assign sp_m1    = sp_q - SW'(1);
  assign mem_adr  = rs_i + offset_e;
  assign mem_port = func_e[1];
  assign mem_ack  = mem_port ? port_ack_i : data_ack_i;

  assign is_alu  = (op_e == 3'b000) |
                   (op_e == 3'b001) |
                   (op_e == 3'b010);
  assign is_mem  = (op_e == 3'b011);
  assign is_br   = (op_e == 3'b100);
  assign is_jmp  = (op_e == 3'b101);
  assign is_misc = (op_e == 3'b110);

  assign inst_adr_o = pc_q;

  // Branches test the flags latched by the last ALU op.
  always_comb begin
    taken = 1'b0;
    unique case (func_e[1:0])
      2'b00: taken = z_q;
      2'b01: taken = ~z_q;
      2'b10: taken = c_q;
      2'b11: taken = ~c_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    sp_d       = sp_q;
    push       = 1'b0;
    z_d        = z_q;
    c_d        = c_q;
    inst_cyc_o = 1'b0;
    inst_stb_o = 1'b0;
    data_cyc_o = 1'b0;
    data_stb_o = 1'b0;
    data_we_o  = 1'b0;
    data_adr_o = 8'h00;
    port_cyc_o = 1'b0;
    port_stb_o = 1'b0;
    port_we_o  = 1'b0;
    port_adr_o = 8'h00;
    RegWrt_c   = 1'b0;
    ClkEn_e    = 1'b0;
    RegMux_c   = 2'b00;
    op2_c      = 1'b0;
    ALUOp_c    = 4'h0;
    halt_o     = 1'b0;
`ifdef GUMNUT_INT_EN
    ie_d       = ie_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        // Gated so the strobes read 0 while reset is held.
        inst_cyc_o = rst_i;
        inst_stb_o = rst_i;
        if (inst_ack_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        unique case (1'b1)
          is_alu: begin
            state_d = S_EXEC;
            pc_d    = pc_q;
          end
          is_mem: begin
            state_d = S_MEM;
            pc_d    = pc_q;
          end
          is_br: begin
            if (taken) pc_d = br_tgt;
          end
          is_jmp: begin
            pc_d = addr_e;
            push = func_e[0];
            if (func_e[0]) sp_d = sp_q + SW'(1);
          end
          is_misc: begin
            case (func_e)
              3'b000: begin
                pc_d = stack_q[sp_m1];
                sp_d = sp_m1;
              end
              3'b001: state_d = S_HALT;
`ifdef GUMNUT_INT_EN
              3'b010: ie_d = 1'b1;
              3'b011: ie_d = 1'b0;
              3'b100: begin
                pc_d = spc_q;
                z_d  = sz_q;
                c_d  = sc_q;
                ie_d = 1'b1;
              end
`endif
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        ClkEn_e  = 1'b1;
        RegWrt_c = 1'b1;
        op2_c    = (op_e == 3'b000);
        ALUOp_c  = {op_e == 3'b010, func_e};
        z_d      = zero_e;
        c_d      = carry_e;
        pc_d     = pc_inc;
        state_d  = S_FETCH;
      end
      S_MEM: begin
        if (mem_port) begin
          port_cyc_o = 1'b1;
          port_stb_o = 1'b1;
          port_we_o  = func_e[0];
          port_adr_o = mem_adr;
        end else begin
          data_cyc_o = 1'b1;
          data_stb_o = 1'b1;
          data_we_o  = func_e[0];
          data_adr_o = mem_adr;
        end
        if (mem_ack) begin
          if (!func_e[0]) begin
            ClkEn_e  = 1'b1;
            RegWrt_c = 1'b1;
            RegMux_c = mem_port ? 2'b10 : 2'b01;
          end
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        halt_o = 1'b1;
`ifdef GUMNUT_INT_EN
        if (int_req_i && ie_q) state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

`ifdef GUMNUT_INT_EN
  assign int_take = int_req_i & ie_d &
                    (state_d == S_FETCH) &
                    (state_q != S_FETCH);
  assign int_ack_o = int_ack_q;
`else
  assign int_take = 1'b0;
`endif

  assign pc_n = int_take ? 12'h001 : pc_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_n;
      sp_q    <= sp_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < STACK_DEPTH; i++)
        stack_q[i] <= '0;
    end else if (push) begin
      stack_q[sp_q] <= pc_inc;
    end
  end

`ifdef GUMNUT_INT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ie_q      <= 1'b0;
      spc_q     <= 12'h000;
      sz_q      <= 1'b0;
      sc_q      <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      ie_q      <= int_take ? 1'b0 : ie_d;
      int_ack_q <= int_take;
      if (int_take) begin
        spc_q <= pc_d;
        sz_q  <= z_d;
        sc_q  <= c_d;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gumnut_ctrl_unit.sv
// Bench for gumnut_ctrl_unit: fetch-address scoreboard plus per-feature checks.
// Interrupt scenario is compiled in when GUMNUT_INT_EN is defined.
`timescale 1ns/1ps
module tb_gumnut_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        inst_ack_i = 1'b0;
  logic        inst_cyc_o, inst_stb_o;
  logic [11:0] inst_adr_o;
  logic [2:0]  op_e = 3'b111;
  logic [2:0]  func_e = 3'b000;
  logic [11:0] addr_e = 12'h000;
  logic [7:0]  disp_e = 8'h00;
  logic [7:0]  offset_e = 8'h00;
  logic [7:0]  rs_i = 8'h00;
  logic        carry_e = 1'b0;
  logic        zero_e = 1'b0;
  logic        data_ack_i = 1'b0;
  logic        data_cyc_o, data_stb_o, data_we_o;
  logic [7:0]  data_adr_o;
  logic        port_ack_i = 1'b0;
  logic        port_cyc_o, port_stb_o, port_we_o;
  logic [7:0]  port_adr_o;
  logic        RegWrt_c, ClkEn_e, op2_c, halt_o;
  logic [1:0]  RegMux_c;
  logic [3:0]  ALUOp_c;
`ifdef GUMNUT_INT_EN
  logic        int_req_i = 1'b0;
  logic        int_ack_o;
`endif

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q [$];

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  fn;
    logic [11:0] arg;
    logic [11:0] nxt;
  } step_t;

  always #5 clk = ~clk;

  gumnut_ctrl_unit dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .inst_ack_i (inst_ack_i),
    .inst_cyc_o (inst_cyc_o),
    .inst_stb_o (inst_stb_o),
    .inst_adr_o (inst_adr_o),
    .op_e       (op_e),
    .func_e     (func_e),
    .addr_e     (addr_e),
    .disp_e     (disp_e),
    .offset_e   (offset_e),
    .rs_i       (rs_i),
    .carry_e    (carry_e),
    .zero_e     (zero_e),
    .data_ack_i (data_ack_i),
    .data_cyc_o (data_cyc_o),
    .data_stb_o (data_stb_o),
    .data_we_o  (data_we_o),
    .data_adr_o (data_adr_o),
    .port_ack_i (port_ack_i),
    .port_cyc_o (port_cyc_o),
    .port_stb_o (port_stb_o),
    .port_we_o  (port_we_o),
    .port_adr_o (port_adr_o),
    .RegWrt_c   (RegWrt_c),
    .ClkEn_e    (ClkEn_e),
    .RegMux_c   (RegMux_c),
    .op2_c      (op2_c),
    .ALUOp_c    (ALUOp_c),
    .halt_o     (halt_o)
`ifdef GUMNUT_INT_EN
    ,
    .int_req_i  (int_req_i),
    .int_ack_o  (int_ack_o)
`endif
  );

  // Waits (bounded) for a fetch, presents the instruction fields, acks once.
  task automatic serve(input logic [2:0] op, input logic [2:0] fn,
                       input logic [11:0] arg,
                       output logic [11:0] adr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_stb_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    adr = inst_adr_o;
    if (ok) begin
      op_e       = op;
      func_e     = fn;
      addr_e     = arg;
      disp_e     = arg[7:0];
      offset_e   = arg[7:0];
      inst_ack_i = 1'b1;
      @(negedge clk);
      inst_ack_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({inst_cyc_o, inst_stb_o, data_cyc_o, data_stb_o,
         port_cyc_o, port_stb_o, halt_o} !== 7'b0) begin
      errors++;
      $display("FAIL reset_bus got=%b want=0", {inst_cyc_o, inst_stb_o,
               data_cyc_o, data_stb_o, port_cyc_o, port_stb_o, halt_o});
    end
    checks++;
    if ({RegWrt_c, ClkEn_e, RegMux_c, op2_c, ALUOp_c} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0",
               {RegWrt_c, ClkEn_e, RegMux_c, op2_c, ALUOp_c});
    end
    checks++;
    if (inst_adr_o !== 12'h000) begin
      errors++;
      $display("FAIL reset_pc got=%h want=000", inst_adr_o);
    end
    rst_i = 1'b1;
    exp_q.push_back(12'h000);
  endtask

  task automatic test_fetch_alu();
    logic [11:0] adr, e;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      serve(3'b111, 3'b000, 12'h000, adr, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || adr !== e) begin
        errors++;
        $display("FAIL fetch_seq got=%h want=%h", adr, e);
      end
      exp_q.push_back(e + 12'd1);
    end
    serve(3'b000, 3'b000, 12'h000, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL fetch_add got=%h want=%h", adr, e);
    end
    @(negedge clk);
    checks++;
    if ({RegWrt_c, ClkEn_e, op2_c, ALUOp_c, RegMux_c} !== 9'b1_1_1_0000_00) begin
      errors++;
      $display("FAIL exec_add got=%b want=111000000",
               {RegWrt_c, ClkEn_e, op2_c, ALUOp_c, RegMux_c});
    end
    exp_q.push_back(12'h003);
    serve(3'b010, 3'b101, 12'h000, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL fetch_shift got=%h want=%h", adr, e);
    end
    @(negedge clk);
    zero_e  = 1'b1;
    carry_e = 1'b1;
    checks++;
    if ({RegWrt_c, ClkEn_e, op2_c, ALUOp_c, RegMux_c} !== 9'b1_1_0_1101_00) begin
      errors++;
      $display("FAIL exec_shift got=%b want=110110100",
               {RegWrt_c, ClkEn_e, op2_c, ALUOp_c, RegMux_c});
    end
    exp_q.push_back(12'h004);
    @(negedge clk);
    zero_e  = 1'b0;
    carry_e = 1'b0;
  endtask

  task automatic test_branch();
    logic [11:0] adr, e;
    bit ok;
    step_t s [6];
    s[0] = '{3'b101, 3'b000, 12'h010, 12'h010};
    s[1] = '{3'b100, 3'b000, 12'h0FE, 12'h00F};
    s[2] = '{3'b111, 3'b000, 12'h000, 12'h010};
    s[3] = '{3'b100, 3'b001, 12'h0FE, 12'h011};
    s[4] = '{3'b100, 3'b010, 12'h004, 12'h016};
    s[5] = '{3'b100, 3'b011, 12'h004, 12'h017};
    foreach (s[i]) begin
      serve(s[i].op, s[i].fn, s[i].arg, adr, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || adr !== e) begin
        errors++;
        $display("FAIL branch_fetch%0d got=%h want=%h", i, adr, e);
      end
      exp_q.push_back(s[i].nxt);
    end
  endtask

  task automatic test_mem();
    logic [11:0] adr, e;
    bit ok;
    rs_i = 8'h10;
    serve(3'b011, 3'b000, 12'h0F8, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL ldm_fetch got=%h want=%h", adr, e);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      port_ack_i = (k == 0);
      checks++;
      if ({data_cyc_o, data_stb_o, data_we_o, port_stb_o, RegWrt_c} !== 5'b11000 ||
          data_adr_o !== 8'h08) begin
        errors++;
        $display("FAIL ldm_wait%0d got=%b adr=%h want=11000 adr=08", k,
                 {data_cyc_o, data_stb_o, data_we_o, port_stb_o, RegWrt_c},
                 data_adr_o);
      end
    end
    @(negedge clk);
    port_ack_i = 1'b0;
    data_ack_i = 1'b1;
    #1;
    checks++;
    if ({data_stb_o, RegWrt_c, ClkEn_e, RegMux_c} !== 5'b11101) begin
      errors++;
      $display("FAIL ldm_ack got=%b want=11101",
               {data_stb_o, RegWrt_c, ClkEn_e, RegMux_c});
    end
    @(negedge clk);
    data_ack_i = 1'b0;
    checks++;
    if ({data_stb_o, RegWrt_c, RegMux_c} !== 4'b0000) begin
      errors++;
      $display("FAIL ldm_after got=%b want=0000",
               {data_stb_o, RegWrt_c, RegMux_c});
    end
    exp_q.push_back(12'h018);
    rs_i = 8'h20;
    serve(3'b011, 3'b011, 12'h005, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL out_fetch got=%h want=%h", adr, e);
    end
    @(negedge clk);
    port_ack_i = 1'b1;
    #1;
    checks++;
    if ({port_cyc_o, port_stb_o, port_we_o, data_stb_o, RegWrt_c} !== 5'b11100 ||
        port_adr_o !== 8'h25) begin
      errors++;
      $display("FAIL out_cycle got=%b adr=%h want=11100 adr=25",
               {port_cyc_o, port_stb_o, port_we_o, data_stb_o, RegWrt_c},
               port_adr_o);
    end
    @(negedge clk);
    port_ack_i = 1'b0;
    exp_q.push_back(12'h019);
  endtask

  task automatic test_jsb_ret();
    logic [11:0] adr, e, cur, t;
    logic [11:0] m [8];
    bit ok;
    int sp;
    sp = 0;
    serve(3'b101, 3'b000, 12'h050, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL jmp_fetch got=%h want=%h", adr, e);
    end
    exp_q.push_back(12'h050);
    cur = 12'h050;
    for (int k = 0; k < 10; k++) begin
      t = (k == 0) ? 12'h123 : 12'h200 + 12'((k - 1) * 16);
      if (k == 1) begin
        serve(3'b110, 3'b000, 12'h000, adr, ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || adr !== e) begin
          errors++;
          $display("FAIL ret_fetch got=%h want=%h", adr, e);
        end
        sp = (sp + 7) % 8;
        exp_q.push_back(m[sp]);
        cur = m[sp];
      end
      serve(3'b101, 3'b001, t, adr, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || adr !== e) begin
        errors++;
        $display("FAIL jsb_fetch%0d got=%h want=%h", k, adr, e);
      end
      m[sp] = cur + 12'd1;
      sp = (sp + 1) % 8;
      exp_q.push_back(t);
      cur = t;
    end
    for (int r = 0; r < 9; r++) begin
      serve(3'b110, 3'b000, 12'h000, adr, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || adr !== e) begin
        errors++;
        $display("FAIL nest_ret%0d got=%h want=%h", r, adr, e);
      end
      sp = (sp + 7) % 8;
      exp_q.push_back(m[sp]);
    end
  endtask

  task automatic test_halt();
    logic [11:0] adr, e;
    bit ok;
    serve(3'b110, 3'b001, 12'h000, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL stby_fetch got=%h want=%h", adr, e);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++;
      if ({halt_o, inst_stb_o, data_stb_o, port_stb_o} !== 4'b1000) begin
        errors++;
        $display("FAIL halt%0d got=%b want=1000", k,
                 {halt_o, inst_stb_o, data_stb_o, port_stb_o});
      end
    end
  endtask

  task automatic test_reset_mid_port();
    logic [11:0] adr, e;
    bit ok;
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    exp_q.delete();
    exp_q.push_back(12'h000);
    rs_i = 8'h00;
    serve(3'b011, 3'b010, 12'h033, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL inp_fetch got=%h want=%h", adr, e);
    end
    @(negedge clk);
    checks++;
    if ({port_stb_o, port_we_o} !== 2'b10 || port_adr_o !== 8'h33) begin
      errors++;
      $display("FAIL inp_cycle got=%b adr=%h want=10 adr=33",
               {port_stb_o, port_we_o}, port_adr_o);
    end
    #2 rst_i = 1'b0;
    #1;
    checks++;
    if ({port_cyc_o, port_stb_o, inst_stb_o} !== 3'b000) begin
      errors++;
      $display("FAIL async_drop got=%b want=000",
               {port_cyc_o, port_stb_o, inst_stb_o});
    end
    @(negedge clk);
    rst_i = 1'b1;
    port_ack_i = 1'b1;
    #1;
    checks++;
    if ({RegWrt_c, port_stb_o, inst_stb_o} !== 3'b001 || inst_adr_o !== 12'h000) begin
      errors++;
      $display("FAIL late_ack got=%b adr=%h want=001 adr=000",
               {RegWrt_c, port_stb_o, inst_stb_o}, inst_adr_o);
    end
    @(negedge clk);
    port_ack_i = 1'b0;
    exp_q.push_back(12'h000);
    for (int i = 0; i < 2; i++) begin
      serve(3'b111, 3'b000, 12'h000, adr, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || adr !== e) begin
        errors++;
        $display("FAIL restart%0d got=%h want=%h", i, adr, e);
      end
      exp_q.push_back(e + 12'd1);
    end
  endtask

`ifdef GUMNUT_INT_EN
  task automatic test_interrupt();
    logic [11:0] adr, e;
    bit ok;
    step_t s [4];
    rst_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    exp_q.delete();
    exp_q.push_back(12'h000);
    serve(3'b000, 3'b000, 12'h000, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL int_add_fetch got=%h want=%h", adr, e);
    end
    @(negedge clk);
    zero_e  = 1'b1;
    carry_e = 1'b0;
    int_req_i = 1'b1;
    exp_q.push_back(12'h001);
    serve(3'b110, 3'b010, 12'h000, adr, ok);
    zero_e = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL enai_fetch got=%h want=%h", adr, e);
    end
    @(negedge clk);
    checks++;
    if ({int_ack_o, inst_stb_o} !== 2'b11 || inst_adr_o !== 12'h001) begin
      errors++;
      $display("FAIL int_entry got=%b adr=%h want=11 adr=001",
               {int_ack_o, inst_stb_o}, inst_adr_o);
    end
    int_req_i = 1'b0;
    exp_q.push_back(12'h001);
    serve(3'b000, 3'b000, 12'h000, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL isr_fetch got=%h want=%h", adr, e);
    end
    @(negedge clk);
    zero_e  = 1'b0;
    carry_e = 1'b1;
    checks++;
    if (int_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL int_ack_pulse got=%b want=0", int_ack_o);
    end
    exp_q.push_back(12'h002);
    s[0] = '{3'b111, 3'b000, 12'h000, 12'h003};
    s[1] = '{3'b110, 3'b100, 12'h000, 12'h002};
    s[2] = '{3'b100, 3'b000, 12'h005, 12'h008};
    s[3] = '{3'b100, 3'b011, 12'h005, 12'h00E};
    foreach (s[i]) begin
      serve(s[i].op, s[i].fn, s[i].arg, adr, ok);
      carry_e = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (!ok || adr !== e) begin
        errors++;
        $display("FAIL reti_seq%0d got=%h want=%h", i, adr, e);
      end
      exp_q.push_back(s[i].nxt);
    end
    serve(3'b111, 3'b000, 12'h000, adr, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || adr !== e) begin
      errors++;
      $display("FAIL reti_flags got=%h want=%h", adr, e);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fetch_alu();
    test_branch();
    test_mem();
    test_jsb_ret();
    test_halt();
    test_reset_mid_port();
`ifdef GUMNUT_INT_EN
    test_interrupt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
